// File: rtl/booth_wallace_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : booth_wallace_mult_pipe
// Purpose  : Four-stage pipelined radix-4 Booth / Wallace-tree multiplier with
//            valid/ready handshakes, per-operation signed/unsigned mode, a
//            sideband tag, backpressure stall and synchronous flush.
//            One product per cycle when not stalled.
// Ports    : clk, rst_n        - clock, asynchronous active-low reset
//            flush             - synchronous clear of every in-flight op
//            in_valid/in_ready - operand handshake (in_ready is combinational
//                                from out_ready and flush)
//            in_signed         - 1: operands are two's complement, 0: unsigned
//            in_a, in_b        - multiplicand / multiplier (WIDTH bits)
//            in_tag            - sideband tag returned with the product
//            out_valid/out_ready - product handshake
//            out_p, out_tag    - product (2*WIDTH bits) and its tag
//            busy              - OR of all stage valid bits
// Params   : WIDTH (even, >= 4), TAG_W
// Revision : 1.0 - initial release
// ============================================================================
module booth_wallace_mult_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_signed,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 busy
);

    localparam int c_prod_w = 2 * WIDTH;
    // Radix-4 digits over the (WIDTH+2)-bit extended multiplier.
    localparam int c_npp    = WIDTH / 2 + 1;
    // One extra row collects the "+1" of every negated partial product.
    localparam int c_nrows  = c_npp + 1;

    // Number of 3:2 reduction levels needed to bring c_nrows rows down to 2.
    function automatic int tree_levels(input int rows);
        int n;
        int l;
        n = rows;
        l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + (n % 3);
            l = l + 1;
        end
        return l;
    endfunction

    localparam int c_levels = tree_levels(c_nrows);

    // Wallace reduction: every level compresses each full group of three rows
    // into a sum row and a (left-shifted) carry row; leftover rows pass
    // through. Returns {carry, sum} with carry un-weighted, so that the final
    // adder computes sum + (carry << 1).
    function automatic logic [2*c_prod_w-1:0] wallace_reduce(
        input logic [c_prod_w-1:0] rows [c_nrows]
    );
        logic [c_prod_w-1:0] cur [c_nrows];
        logic [c_prod_w-1:0] nxt [c_nrows];
        int n;
        int g;
        int r;
        for (int k = 0; k < c_nrows; k++) begin
            cur[k] = rows[k];
        end
        n = c_nrows;
        for (int l = 0; l < c_levels; l++) begin
            g = n / 3;
            r = n % 3;
            for (int k = 0; k < c_nrows; k++) begin
                nxt[k] = '0;
            end
            for (int j = 0; j < c_nrows / 3; j++) begin
                if (j < g) begin
                    nxt[2*j]   = cur[3*j] ^ cur[3*j+1] ^ cur[3*j+2];
                    nxt[2*j+1] = ((cur[3*j] & cur[3*j+1]) |
                                  (cur[3*j] & cur[3*j+2]) |
                                  (cur[3*j+1] & cur[3*j+2])) << 1;
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (k < r) begin
                    nxt[2*g+k] = cur[3*g+k];
                end
            end
            for (int k = 0; k < c_nrows; k++) begin
                cur[k] = nxt[k];
            end
            n = 2 * g + r;
        end
        // The last level always starts from three rows, so row 1 is a carry
        // row whose LSB is zero; shifting it back right loses nothing.
        return {cur[1] >> 1, cur[0]};
    endfunction

    // ------------------------------------------------------------------
    // Handshake / global advance
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic r_s3_valid;
    logic r_s4_valid;
    logic w_adv;
    logic w_take;

    assign w_adv     = ~r_s4_valid | out_ready;
    assign in_ready  = w_adv & ~flush;
    assign w_take    = in_valid & in_ready;
    assign out_valid = r_s4_valid;
    assign busy      = r_s1_valid | r_s2_valid | r_s3_valid | r_s4_valid;

    // Valid bits: flush wins over advance; bubbles move with the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s4_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s3_valid <= 1'b0;
            r_s4_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= w_take;
            r_s2_valid <= r_s1_valid;
            r_s3_valid <= r_s2_valid;
            r_s4_valid <= r_s3_valid;
        end
    end

    // ------------------------------------------------------------------
    // S1: operands, mode, tag
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_signed;
    logic [TAG_W-1:0] r_s1_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_a      <= '0;
            r_s1_b      <= '0;
            r_s1_signed <= 1'b0;
            r_s1_tag    <= '0;
        end else if (w_take) begin
            r_s1_a      <= in_a;
            r_s1_b      <= in_b;
            r_s1_signed <= in_signed;
            r_s1_tag    <= in_tag;
        end
    end

    // ------------------------------------------------------------------
    // Booth radix-4 partial products (S1 -> S2)
    // ------------------------------------------------------------------
    logic [c_prod_w-1:0] w_a_ext;
    logic [WIDTH+2:0]    w_b_z;       // {ext, ext, b, implicit 0 below LSB}
    logic [c_prod_w-1:0] w_pp [c_nrows];

    always_comb begin
        w_a_ext = {{WIDTH{r_s1_signed & r_s1_a[WIDTH-1]}}, r_s1_a};
        w_b_z   = {{2{r_s1_signed & r_s1_b[WIDTH-1]}}, r_s1_b, 1'b0};
        for (int k = 0; k < c_nrows; k++) begin
            w_pp[k] = '0;
        end
        // Negative digits use the one's complement of the multiple; the
        // missing +1 is placed at bit 2i of the correction row.
        for (int i = 0; i < c_npp; i++) begin
            case (w_b_z[2*i +: 3])
                3'b001, 3'b010: w_pp[i] = w_a_ext << (2 * i);
                3'b011:         w_pp[i] = (w_a_ext << 1) << (2 * i);
                3'b100: begin
                    w_pp[i]          = (~(w_a_ext << 1)) << (2 * i);
                    w_pp[c_npp][2*i] = 1'b1;
                end
                3'b101, 3'b110: begin
                    w_pp[i]          = (~w_a_ext) << (2 * i);
                    w_pp[c_npp][2*i] = 1'b1;
                end
                default:        w_pp[i] = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // S2: partial products
    // ------------------------------------------------------------------
    logic [c_prod_w-1:0] r_s2_pp [c_nrows];
    logic [TAG_W-1:0]    r_s2_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_nrows; k++) begin
                r_s2_pp[k] <= '0;
            end
            r_s2_tag <= '0;
        end else if (w_adv) begin
            for (int k = 0; k < c_nrows; k++) begin
                r_s2_pp[k] <= w_pp[k];
            end
            r_s2_tag <= r_s1_tag;
        end
    end

    // ------------------------------------------------------------------
    // Wallace tree (S2 -> S3)
    // ------------------------------------------------------------------
    logic [2*c_prod_w-1:0] w_tree;

    assign w_tree = wallace_reduce(r_s2_pp);

    // ------------------------------------------------------------------
    // S3: sum / carry pair
    // ------------------------------------------------------------------
    logic [c_prod_w-1:0] r_s3_sum;
    logic [c_prod_w-1:0] r_s3_carry;
    logic [TAG_W-1:0]    r_s3_tag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_sum   <= '0;
            r_s3_carry <= '0;
            r_s3_tag   <= '0;
        end else if (w_adv) begin
            r_s3_sum   <= w_tree[c_prod_w-1:0];
            r_s3_carry <= w_tree[2*c_prod_w-1:c_prod_w];
            r_s3_tag   <= r_s2_tag;
        end
    end

    // ------------------------------------------------------------------
    // S4: carry-propagate adder, modulo 2^(2*WIDTH)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p   <= '0;
            out_tag <= '0;
        end else if (w_adv) begin
            out_p   <= r_s3_sum + (r_s3_carry << 1);
            out_tag <= r_s3_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_booth_wallace_mult_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_wallace_mult_pipe
// Purpose  : Self-checking bench for booth_wallace_mult_pipe. Three instances
//            (WIDTH 8, 16, 4) share clock and reset; each has a scoreboard
//            queue filled with exact products at every accepted handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_wallace_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // WIDTH = 8 instance
    logic f8, v8, s8, or8;
    logic [7:0] a8, b8;
    logic [3:0] t8;
    logic ir8, ov8, busy8;
    logic [15:0] p8;
    logic [3:0] ot8;
    // WIDTH = 16 instance
    logic f16, v16, s16, or16;
    logic [15:0] a16, b16;
    logic [3:0] t16;
    logic ir16, ov16, busy16;
    logic [31:0] p16;
    logic [3:0] ot16;
    // WIDTH = 4 instance
    logic f4, v4, s4, or4;
    logic [3:0] a4, b4;
    logic [3:0] t4;
    logic ir4, ov4, busy4;
    logic [7:0] p4;
    logic [3:0] ot4;

    booth_wallace_mult_pipe #(.WIDTH(8), .TAG_W(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .flush(f8), .in_valid(v8), .in_ready(ir8),
        .in_signed(s8), .in_a(a8), .in_b(b8), .in_tag(t8), .out_valid(ov8),
        .out_ready(or8), .out_p(p8), .out_tag(ot8), .busy(busy8));
    booth_wallace_mult_pipe #(.WIDTH(16), .TAG_W(4)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .flush(f16), .in_valid(v16), .in_ready(ir16),
        .in_signed(s16), .in_a(a16), .in_b(b16), .in_tag(t16), .out_valid(ov16),
        .out_ready(or16), .out_p(p16), .out_tag(ot16), .busy(busy16));
    booth_wallace_mult_pipe #(.WIDTH(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(f4), .in_valid(v4), .in_ready(ir4),
        .in_signed(s4), .in_a(a4), .in_b(b4), .in_tag(t4), .out_valid(ov4),
        .out_ready(or4), .out_p(p4), .out_tag(ot4), .busy(busy4));

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Exact product of two w-bit operands, reduced to 2w bits.
    function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                             input logic s, input int w);
        longint av, bv, pr;
        av = longint'(a);
        bv = longint'(b);
        if (s && a[w-1]) av = av - (longint'(1) << w);
        if (s && b[w-1]) bv = bv - (longint'(1) << w);
        pr = av * bv;
        return 64'(pr) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    typedef struct {
        logic [63:0] p;
        logic [3:0]  tag;
        int          acc;
    } exp_t;

    exp_t q8[$], q16[$], q4[$];
    logic [63:0] obs8[$];
    logic [63:0] exp_v[4];
    bit lat_chk8 = 1'b0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboards (sampled on the falling edge) ----------
    initial begin
        exp_t e;
        bit h;
        logic [15:0] hp;
        logic [3:0] ht;
        h = 0; hp = '0; ht = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q8.delete();
                h = 0;
            end else begin
                check_val("busy8", busy8, q8.size() != 0);
                check_val("rdy8", ir8, (!ov8 || or8) && !f8);
                if (h) begin
                    check_val("hold_p8", p8, hp);
                    check_val("hold_tag8", ot8, ht);
                end
                if (ov8 && or8) begin
                    if (q8.size() == 0) check_val("extra8", ov8, 0);
                    else begin
                        e = q8.pop_front();
                        check_val("p8", p8, e.p);
                        check_val("tag8", ot8, e.tag);
                        obs8.push_back(64'(p8));
                        if (lat_chk8) check_val("lat8", cyc - e.acc, 3);
                    end
                end
                if (f8) q8.delete();
                if (v8 && ir8) begin
                    e.p = ref_prod(32'(a8), 32'(b8), s8, 8);
                    e.tag = t8;
                    e.acc = cyc + 1;
                    q8.push_back(e);
                end
                h = ov8 && !or8; hp = p8; ht = ot8;
            end
        end
    end

    initial begin
        exp_t e;
        bit h;
        logic [31:0] hp;
        logic [3:0] ht;
        h = 0; hp = '0; ht = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q16.delete();
                h = 0;
            end else begin
                check_val("busy16", busy16, q16.size() != 0);
                check_val("rdy16", ir16, (!ov16 || or16) && !f16);
                if (h) begin
                    check_val("hold_p16", p16, hp);
                    check_val("hold_tag16", ot16, ht);
                end
                if (ov16 && or16) begin
                    if (q16.size() == 0) check_val("extra16", ov16, 0);
                    else begin
                        e = q16.pop_front();
                        check_val("p16", p16, e.p);
                        check_val("tag16", ot16, e.tag);
                    end
                end
                if (f16) q16.delete();
                if (v16 && ir16) begin
                    e.p = ref_prod(32'(a16), 32'(b16), s16, 16);
                    e.tag = t16;
                    e.acc = cyc + 1;
                    q16.push_back(e);
                end
                h = ov16 && !or16; hp = p16; ht = ot16;
            end
        end
    end

    initial begin
        exp_t e;
        bit h;
        logic [7:0] hp;
        logic [3:0] ht;
        h = 0; hp = '0; ht = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                q4.delete();
                h = 0;
            end else begin
                check_val("busy4", busy4, q4.size() != 0);
                check_val("rdy4", ir4, (!ov4 || or4) && !f4);
                if (h) begin
                    check_val("hold_p4", p4, hp);
                    check_val("hold_tag4", ot4, ht);
                end
                if (ov4 && or4) begin
                    if (q4.size() == 0) check_val("extra4", ov4, 0);
                    else begin
                        e = q4.pop_front();
                        check_val("p4", p4, e.p);
                        check_val("tag4", ot4, e.tag);
                    end
                end
                if (f4) q4.delete();
                if (v4 && ir4) begin
                    e.p = ref_prod(32'(a4), 32'(b4), s4, 4);
                    e.tag = t4;
                    e.acc = cyc + 1;
                    q4.push_back(e);
                end
                h = ov4 && !or4; hp = p4; ht = ot4;
            end
        end
    end

    // ---------------- stimulus helpers (called at posedge + 1) -----------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers one operation and holds it until accepted.
    task automatic send8(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic [3:0] t);
        int n;
        a8 = a; b8 = b; s8 = s; t8 = t; v8 = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (ir8) break;
            n++;
            if (n > 50) begin
                check_val("send_timeout", ir8, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        v8 = 1'b0;
    endtask

    task automatic chk_obs(input string tag, input int n);
        check_val({tag, "_count"}, obs8.size(), n);
        for (int i = 0; i < n; i++) begin
            check_val(tag, (i < obs8.size()) ? obs8[i] : 64'hx, exp_v[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit hold16, hold4;
        rst_n = 1'b0;
        {f8, v8, s8, a8, b8, t8} = '0;
        {f16, v16, s16, a16, b16, t16} = '0;
        {f4, v4, s4, a4, b4, t4} = '0;
        or8 = 1'b1; or16 = 1'b1; or4 = 1'b1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        check_val("rst_out_valid", ov8, 0);
        check_val("rst_out_p", p8, 0);
        check_val("rst_out_tag", ot8, 0);
        check_val("rst_busy", busy8, 0);
        check_val("rst_in_ready8", ir8, 1);
        check_val("rst_in_ready16", ir16, 1);
        check_val("rst_in_ready4", ir4, 1);
        @(posedge clk);
        #1;

        // Signed corners, back to back, latency 3
        lat_chk8 = 1'b1;
        obs8.delete();
        send8(8'h80, 8'h80, 1'b1, 4'd1);
        send8(8'h80, 8'h7F, 1'b1, 4'd2);
        send8(8'hFF, 8'h01, 1'b1, 4'd3);
        wait_cycles(6);
        exp_v[0] = 64'h4000; exp_v[1] = 64'hC080; exp_v[2] = 64'hFFFF;
        chk_obs("signed_corner", 3);

        // Unsigned mode, then the same bits in signed mode
        obs8.delete();
        send8(8'hFF, 8'hFF, 1'b0, 4'd4);
        send8(8'hFF, 8'h01, 1'b0, 4'd5);
        send8(8'h80, 8'h80, 1'b0, 4'd6);
        send8(8'hFF, 8'h01, 1'b1, 4'd7);
        wait_cycles(6);
        exp_v[0] = 64'hFE01; exp_v[1] = 64'h00FF; exp_v[2] = 64'h4000; exp_v[3] = 64'hFFFF;
        chk_obs("unsigned", 4);

        // Backpressure: 5-cycle stall in the middle of a 6-op stream
        lat_chk8 = 1'b0;
        obs8.delete();
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send8(8'($urandom), 8'($urandom), 1'(i % 2), 4'(8 + i));
            end
            begin
                wait_cycles(4);
                or8 = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check_val("bp_in_ready", ir8, 0);
                    @(posedge clk);
                    #1;
                end
                or8 = 1'b1;
            end
        join
        wait_cycles(8);
        check_val("bp_count", obs8.size(), 6);

        // Flush before any result emerges
        lat_chk8 = 1'b1;
        obs8.delete();
        send8(8'd11, 8'd12, 1'b0, 4'd1);
        send8(8'd13, 8'd14, 1'b0, 4'd2);
        send8(8'd15, 8'd16, 1'b0, 4'd3);
        f8 = 1'b1; v8 = 1'b1; a8 = 8'd99; b8 = 8'd99; t8 = 4'd15;
        @(negedge clk);
        check_val("flush_in_ready", ir8, 0);
        @(posedge clk);
        #1;
        f8 = 1'b0; v8 = 1'b0;
        check_val("flush_busy", busy8, 0);
        check_val("flush_out_valid", ov8, 0);
        send8(8'd3, 8'd5, 1'b0, 4'd9);
        wait_cycles(6);
        exp_v[0] = 64'h000F;
        chk_obs("after_flush", 1);

        // Asynchronous reset with operations in flight
        lat_chk8 = 1'b0;
        obs8.delete();
        send8(8'd21, 8'd22, 1'b1, 4'd1);
        send8(8'd23, 8'd24, 1'b1, 4'd2);
        send8(8'd25, 8'd26, 1'b1, 4'd3);
        wait_cycles(1);
        check_val("pre_reset_valid", ov8, 1);
        #2 rst_n = 1'b0;
        #1;
        check_val("areset_out_valid", ov8, 0);
        check_val("areset_busy", busy8, 0);
        check_val("areset_out_p", p8, 0);
        wait_cycles(2);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        wait_cycles(8);
        check_val("no_stale_after_reset", obs8.size(), 0);

        // Randomised operands, modes and out_ready on WIDTH=16 and WIDTH=4
        hold16 = 0; hold4 = 0;
        for (int c = 0; c < 16000; c++) begin
            if (!hold16) begin
                v16 = ($urandom % 8) != 0;
                a16 = 16'($urandom); b16 = 16'($urandom);
                s16 = 1'($urandom); t16 = 4'($urandom);
            end
            if (!hold4) begin
                v4 = ($urandom % 8) != 0;
                a4 = 4'($urandom); b4 = 4'($urandom);
                s4 = 1'($urandom); t4 = 4'($urandom);
            end
            or16 = ($urandom % 4) != 0;
            or4  = ($urandom % 4) != 0;
            @(negedge clk);
            hold16 = v16 && !ir16;
            hold4  = v4 && !ir4;
            @(posedge clk);
            #1;
        end
        v16 = 1'b0; v4 = 1'b0; or16 = 1'b1; or4 = 1'b1;
        wait_cycles(10);
        check_val("drain16", q16.size(), 0);
        check_val("drain4", q4.size(), 0);
        check_val("drain8", q8.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/booth_wallace_mult_pipe.md
Name: booth_wallace_mult_pipe

Overview:
Parametrised, pipelined radix-4 Booth / Wallace-tree multiplier with a valid/ready handshake on both sides. It replaces the fixed 8-bit free-running multiplier in the PE datapath. It adds generic operand width, a per-operation signed/unsigned mode, a sideband tag, backpressure stall and a synchronous flush. Throughput is one product per cycle when not stalled.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 4.
TAG_W, 4, width of the sideband tag carried alongside each operation.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all in-flight operations
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands this cycle
in_signed  input  1  1 = A, B two's complement; 0 = unsigned
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_tag  input  TAG_W  sideband tag, returned unchanged with the result
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
out_p  output  2*WIDTH  product
out_tag  output  TAG_W  tag of this product
busy  output  1  OR of all stage valid bits

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits = 0, all data registers = 0. Outputs are out_valid=0, out_p=0, out_tag=0, busy=0. in_ready=1 once rst_n is high. Reset mid-operation discards all in-flight work with no output.
- Pipeline has four register stages, each with a valid bit:
  - S1: operands, mode and tag.
  - S2: Booth partial products.
  - S3: Wallace sum/carry pair.
  - S4: final adder result = out_p.
- Booth encoding: each operand is extended to WIDTH+2 bits, by sign-extension if in_signed=1, zero-extension if 0. This gives WIDTH/2+1 radix-4 partial products of 2*WIDTH bits, each sign-extended and shifted by 2i.
- Wallace tree: reduces all partial products to a sum/carry pair using 3:2 CSAs, entirely combinational within S2->S3.
- Final adder: the S3->S4 carry-propagate adder computes sum + (carry<<1), truncated to 2*WIDTH bits. The result equals the exact product for every operand and mode; no overflow is possible.
- Global advance: adv = !out_valid || out_ready. When adv=1 all stages shift one step. When adv=0 all stage registers hold.
- in_ready = adv, a combinational path from out_ready. An operation is accepted on an edge where in_valid && in_ready.
- Latency: if accepted at edge e with no stall, out_valid=1 and out_p/out_tag are valid after edge e+3. Each stall cycle adds exactly one cycle.
- Bubbles are not collapsed during a stall; they travel with the pipeline.
- in_valid=1 with in_ready=0: nothing is captured. The source must hold its inputs.
- out_valid=1 with out_ready=0: out_p and out_tag must stay stable until the transfer completes.
- Back-to-back acceptance with out_ready held at 1: one result per cycle, in acceptance order, with tags preserved.
- flush=1 at an edge: all stage valid bits are cleared. Any in_valid on that edge is not accepted (in_ready is forced to 0 while flush=1). Data registers may keep stale values. flush takes priority over adv.
- busy=0 implies the block is idle and safe to reconfigure.
- When a stage is invalid, its data registers must not change the output: out_p and out_tag are only meaningful when out_valid=1.

Test Plan:
- Signed corners, WIDTH=8, out_ready=1: send (-128,-128), then (-128,127), then (-1,1). Required: out_p = 0x4000, then 0xC080, then 0xFFFF, on consecutive cycles 3 cycles after each accept, with tags 1,2,3 returned in order.
- Unsigned mode, WIDTH=8: send (0xFF,0xFF), then (0xFF,0x01), then (0x80,0x80). Required: 0xFE01, then 0x00FF, then 0x4000. Also send the same bits (0xFF,0x01) with signed=1. Required: 0xFFFF.
- Backpressure: stream 6 ops, then drop out_ready for 5 cycles mid-stream. Required: in_ready=0 during the stall, out_p/out_tag held stable, no loss or duplication, and all 6 products correct in order.
- Flush: accept 3 ops, then assert flush for 1 cycle before any result emerges. Required: out_valid never rises for those 3 and busy=0 after the flush edge. A new op accepted next cycle appears with latency 3.
- Async reset mid-stream: drop rst_n between edges with 3 ops in flight. Required: out_valid and busy fall immediately, out_p=0, and no stale result appears after rst_n is released.
- Randomised: with WIDTH=16 and WIDTH=4, use 10k random operands, modes and out_ready patterns, compared against a reference model's exact product. Required: zero mismatches.
